// File: rtl/array_sched.sv
// array_sched: steers sof..eof frames to the write/read engines, pulses
// their start, waits for done, and interleaves postponable refreshes.
// Ports: clk/rst_n; frame_* upstream stream; array_wframe_*/array_wr_*
// write engine; array_rframe_*/array_rd_* read engine; array_ref_*
// refresh engine; cfg_tREFI interval (0 = off); sts_* status.
module array_sched #(
  parameter int ARRAY_COL_ADDR_WIDTH   = 6,
  parameter int ARRAY_ROW_ADDR_WIDTH   = 16,
  parameter int ARRAY_DATA_WIDTH       = 64,
  parameter int ARRAY_FRAME_DATA_WIDTH = 3 + ARRAY_COL_ADDR_WIDTH
                                       + ARRAY_ROW_ADDR_WIDTH
                                       + ARRAY_DATA_WIDTH,
  parameter int REF_POSTPONE_MAX       = 7
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              frame_valid,
  input  logic [ARRAY_FRAME_DATA_WIDTH-1:0] frame_data,
  output logic                              frame_ready,
  output logic                              array_wframe_valid,
  output logic [ARRAY_FRAME_DATA_WIDTH-1:0] array_wframe_data,
  input  logic                              array_wframe_ready,
  output logic                              array_wr_start,
  input  logic                              array_wr_done,
  output logic                              array_rframe_valid,
  output logic [ARRAY_FRAME_DATA_WIDTH-1:0] array_rframe_data,
  input  logic                              array_rframe_ready,
  output logic                              array_rd_start,
  input  logic                              array_rd_done,
  output logic                              array_ref_start,
  input  logic                              array_ref_done,
  input  logic [15:0]                       cfg_tREFI,
  output logic                              sts_busy,
  output logic [2:0]                        sts_ref_pending,
  output logic                              sts_ref_overflow,
  output logic [7:0]                        sts_drop_cnt
);

  localparam int FW = ARRAY_FRAME_DATA_WIDTH;
  localparam logic [2:0] PEND_MAX = 3'd7;
  localparam logic [2:0] PEND_URG = 3'(REF_POSTPONE_MAX);

  typedef enum logic [2:0] {
    IDLE,
    WR_START,
    WR_BUSY,
    RD_START,
    RD_BUSY,
    REF_START,
    REF_BUSY
  } state_e;

  state_e      state_q, state_d;
  logic        eof_seen_q, eof_seen_d;
  logic [15:0] tmr_q, tmr_d;
  logic        tick_q, tick_d;
  logic [2:0]  pend_q, pend_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  drop_q, drop_d;
  logic        drop;
  logic        ref_dec;

  logic f_eof, f_sof, f_rw;
  assign f_eof = frame_data[FW-1];
  assign f_sof = frame_data[FW-2];
  assign f_rw  = frame_data[FW-3];

  logic urgent;
  assign urgent = (pend_q >= PEND_URG);

  always_comb begin
    state_d            = state_q;
    eof_seen_d         = eof_seen_q;
    frame_ready        = 1'b0;
    array_wframe_valid = 1'b0;
    array_wframe_data  = '0;
    array_rframe_valid = 1'b0;
    array_rframe_data  = '0;
    array_wr_start     = 1'b0;
    array_rd_start     = 1'b0;
    array_ref_start    = 1'b0;
    drop               = 1'b0;
    ref_dec            = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (urgent) begin
          state_d = REF_START;
        end else if (frame_valid && f_sof) begin
          state_d = f_rw ? WR_START : RD_START;
        end else if (frame_valid) begin
          // stray beat outside a frame: swallow it
          frame_ready = 1'b1;
          drop        = 1'b1;
        end else if (pend_q != 3'd0) begin
          state_d = REF_START;
        end
      end
      WR_START: begin
        array_wr_start = 1'b1;
        state_d        = WR_BUSY;
      end
      WR_BUSY: begin
        if (!eof_seen_q) begin
          array_wframe_valid = frame_valid;
          array_wframe_data  = frame_data;
          frame_ready        = array_wframe_ready;
          if (frame_valid && array_wframe_ready && f_eof)
            eof_seen_d = 1'b1;
        end
        if (array_wr_done) begin
          state_d    = IDLE;
          eof_seen_d = 1'b0;
        end
      end
      RD_START: begin
        array_rd_start = 1'b1;
        state_d        = RD_BUSY;
      end
      RD_BUSY: begin
        if (!eof_seen_q) begin
          array_rframe_valid = frame_valid;
          array_rframe_data  = frame_data;
          frame_ready        = array_rframe_ready;
          if (frame_valid && array_rframe_ready && f_eof)
            eof_seen_d = 1'b1;
        end
        if (array_rd_done) begin
          state_d    = IDLE;
          eof_seen_d = 1'b0;
        end
      end
      REF_START: begin
        array_ref_start = 1'b1;
        state_d         = REF_BUSY;
      end
      REF_BUSY: begin
        if (array_ref_done) begin
          ref_dec = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // interval timer; a zero interval parks it at its reload value
  always_comb begin
    tmr_d  = tmr_q - 16'd1;
    tick_d = 1'b0;
    if (cfg_tREFI == 16'd0) begin
      tmr_d = cfg_tREFI - 16'd1;
    end else if (tmr_q == 16'd0) begin
      tmr_d  = cfg_tREFI - 16'd1;
      tick_d = 1'b1;
    end
  end

  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    drop_d = drop_q;
    unique case ({tick_q, ref_dec})
      2'b10: begin
        if (pend_q == PEND_MAX) ovf_d = 1'b1;
        else                    pend_d = pend_q + 3'd1;
      end
      2'b01: begin
        if (pend_q != 3'd0) pend_d = pend_q - 3'd1;
      end
      default: ;
    endcase
    if (drop && drop_q != 8'hFF)
      drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      eof_seen_q <= 1'b0;
      tmr_q      <= cfg_tREFI - 16'd1;
      tick_q     <= 1'b0;
      pend_q     <= '0;
      ovf_q      <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      eof_seen_q <= eof_seen_d;
      tmr_q      <= tmr_d;
      tick_q     <= tick_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
    end
  end

  assign sts_busy         = (state_q != IDLE);
  assign sts_ref_pending  = pend_q;
  assign sts_ref_overflow = ovf_q;
  assign sts_drop_cnt     = drop_q;

endmodule

// File: tb/tb_array_sched.sv
// tb_array_sched: scoreboard bench for array_sched; frame beats are
// queued when driven and matched when they appear on an engine port.
module tb_array_sched;

  localparam int FW = 89;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          frame_valid;
  logic [FW-1:0] frame_data;
  logic          frame_ready;
  logic          wvalid, rvalid;
  logic [FW-1:0] wdata, rdata;
  logic          wready, rready;
  logic          wr_start, rd_start, ref_start;
  logic          wr_done, rd_done, ref_done;
  logic [15:0]   cfg_tREFI;
  logic          busy, ovf;
  logic [2:0]    pend;
  logic [7:0]    drop;

  int n_cmp = 0;
  int n_err = 0;
  logic [FW-1:0] exp_w[$];
  logic [FW-1:0] exp_r[$];

  array_sched dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .frame_valid        (frame_valid),
    .frame_data         (frame_data),
    .frame_ready        (frame_ready),
    .array_wframe_valid (wvalid),
    .array_wframe_data  (wdata),
    .array_wframe_ready (wready),
    .array_wr_start     (wr_start),
    .array_wr_done      (wr_done),
    .array_rframe_valid (rvalid),
    .array_rframe_data  (rdata),
    .array_rframe_ready (rready),
    .array_rd_start     (rd_start),
    .array_rd_done      (rd_done),
    .array_ref_start    (ref_start),
    .array_ref_done     (ref_done),
    .cfg_tREFI          (cfg_tREFI),
    .sts_busy           (busy),
    .sts_ref_pending    (pend),
    .sts_ref_overflow   (ovf),
    .sts_drop_cnt       (drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [95:0] got,
                     input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && wvalid && wready) begin
      if (exp_w.size() == 0) chk("w_extra", 96'(wvalid), 96'(0));
      else chk("w_data", 96'(wdata), 96'(exp_w.pop_front()));
    end
    if (rst_n && rvalid && rready) begin
      if (exp_r.size() == 0) chk("r_extra", 96'(rvalid), 96'(0));
      else chk("r_data", 96'(rdata), 96'(exp_r.pop_front()));
    end
  end

  function automatic logic [FW-1:0] mk(input logic eof, input logic sof,
                                       input logic rw,
                                       input logic [63:0] d,
                                       input logic [15:0] row,
                                       input logic [5:0] col);
    return {eof, sof, rw, d, row, col};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (!frame_ready && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_acc"}, 96'(frame_ready), 96'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic put_beat(input logic [FW-1:0] d, input string tag);
    frame_valid = 1'b1;
    frame_data  = d;
    wait_acc(tag);
    frame_valid = 1'b0;
    frame_data  = '0;
  endtask

  task automatic do_reset(input logic [15:0] cfg);
    rst_n       = 1'b0;
    frame_valid = 1'b0;
    frame_data  = '0;
    wready      = 1'b1;
    rready      = 1'b1;
    wr_done     = 1'b0;
    rd_done     = 1'b0;
    ref_done    = 1'b0;
    cfg_tREFI   = cfg;
    exp_w.delete();
    exp_r.delete();
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic chk_rst(input string p);
    chk({p, "_fready"}, 96'(frame_ready), 96'(0));
    chk({p, "_wrs"},    96'(wr_start),    96'(0));
    chk({p, "_rds"},    96'(rd_start),    96'(0));
    chk({p, "_refs"},   96'(ref_start),   96'(0));
    chk({p, "_wv"},     96'(wvalid),      96'(0));
    chk({p, "_wd"},     96'(wdata),       96'(0));
    chk({p, "_rv"},     96'(rvalid),      96'(0));
    chk({p, "_rd"},     96'(rdata),       96'(0));
    chk({p, "_busy"},   96'(busy),        96'(0));
    chk({p, "_pend"},   96'(pend),        96'(0));
    chk({p, "_ovf"},    96'(ovf),         96'(0));
    chk({p, "_drop"},   96'(drop),        96'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [FW-1:0] f;
    frame_valid = 1'b0;
    frame_data  = '0;
    wready = 1'b1; rready = 1'b1;
    wr_done = 1'b0; rd_done = 1'b0; ref_done = 1'b0;
    cfg_tREFI = 16'd0;
    #3 rst_n = 1'b0;
    #1 chk_rst("rst0");
    do_reset(16'd0);

    // single-beat write
    step(2);
    wready = 1'b0;
    f = mk(1, 1, 1, 64'hDEAD_BEEF_0123_4567, 16'h1234, 6'h05);
    exp_w.push_back(f);
    frame_valid = 1'b1;
    frame_data  = f;
    #1;
    chk("a_idle_fready", 96'(frame_ready), 96'(0));
    chk("a_idle_wrs", 96'(wr_start), 96'(0));
    step(1);
    chk("a_wrs", 96'(wr_start), 96'(1));
    chk("a_wv_start", 96'(wvalid), 96'(0));
    step(1);
    chk("a_wrs_off", 96'(wr_start), 96'(0));
    chk("a_wv", 96'(wvalid), 96'(1));
    chk("a_wdata", 96'(wdata), 96'(f));
    chk("a_fready_lo", 96'(frame_ready), 96'(0));
    wready = 1'b1;
    #1;
    chk("a_fready_hi", 96'(frame_ready), 96'(1));
    step(1);
    frame_data = mk(0, 0, 1, 64'h5555, 16'h1, 6'h1);
    #1;
    chk("a_post_eof_wv", 96'(wvalid), 96'(0));
    chk("a_post_eof_fr", 96'(frame_ready), 96'(0));
    frame_valid = 1'b0;
    wr_done = 1'b1;
    step(1);
    wr_done = 1'b0;
    chk("a_idle_after", 96'(busy), 96'(0));

    // 4-beat read then write
    for (int i = 0; i < 4; i++) begin
      f = mk(i == 3, i == 0, 0, 64'(i * 17 + 3), 16'(100 + i), 6'(i));
      exp_r.push_back(f);
      put_beat(f, "b_rd");
    end
    f = mk(1, 1, 1, 64'hABCD, 16'h0BEE, 6'h2A);
    exp_w.push_back(f);
    frame_valid = 1'b1;
    frame_data  = f;
    #1;
    chk("b_rv_hold", 96'(rvalid), 96'(0));
    chk("b_fr_hold", 96'(frame_ready), 96'(0));
    step(1);
    rd_done = 1'b1;
    step(1);
    rd_done = 1'b0;
    chk("b_idle", 96'(busy), 96'(0));
    chk("b_wrs_m1", 96'(wr_start), 96'(0));
    step(1);
    chk("b_wrs_m2", 96'(wr_start), 96'(1));
    wait_acc("b_wr");
    frame_valid = 1'b0;
    wr_done = 1'b1;
    step(1);
    wr_done = 1'b0;

    // refresh interval 20
    do_reset(16'd20);
    step(20);
    chk("c_pend_e20", 96'(pend), 96'(0));
    step(1);
    chk("c_pend_e21", 96'(pend), 96'(1));
    chk("c_refs_e21", 96'(ref_start), 96'(0));
    step(1);
    chk("c_refs_e22", 96'(ref_start), 96'(1));
    step(1);
    chk("c_refs_off", 96'(ref_start), 96'(0));
    ref_done = 1'b1;
    step(1);
    ref_done = 1'b0;
    chk("c_pend_done", 96'(pend), 96'(0));
    chk("c_busy_done", 96'(busy), 96'(0));

    // refresh saturation while a write is held
    do_reset(16'd10);
    f = mk(1, 1, 1, 64'h77, 16'h2, 6'h3);
    exp_w.push_back(f);
    put_beat(f, "d_wr");
    step(100);
    chk("d_pend_sat", 96'(pend), 96'(7));
    chk("d_ovf", 96'(ovf), 96'(1));
    f = mk(1, 1, 0, 64'h88, 16'h4, 6'h5);
    exp_r.push_back(f);
    frame_valid = 1'b1;
    frame_data  = f;
    wr_done = 1'b1;
    step(1);
    wr_done = 1'b0;
    chk("d_idle", 96'(busy), 96'(0));
    step(1);
    chk("d_refs", 96'(ref_start), 96'(1));
    chk("d_rds", 96'(rd_start), 96'(0));
    step(1);
    ref_done = 1'b1;
    step(1);
    ref_done = 1'b0;
    wait_acc("d_rd");
    frame_valid = 1'b0;
    rd_done = 1'b1;
    step(1);
    rd_done = 1'b0;
    chk("d_ovf_sticky", 96'(ovf), 96'(1));

    // stray beats
    do_reset(16'd0);
    for (int i = 0; i < 3; i++) begin
      frame_valid = 1'b1;
      frame_data  = mk(i == 2, 0, 1, 64'(i), 16'(i), 6'(i));
      #1;
      chk("e_fready", 96'(frame_ready), 96'(1));
      chk("e_start", 96'({wr_start, rd_start}), 96'(0));
      step(1);
    end
    frame_valid = 1'b0;
    #1;
    chk("e_drop", 96'(drop), 96'(3));
    chk("e_busy", 96'(busy), 96'(0));

    // reset during WR_BUSY
    wready = 1'b0;
    frame_valid = 1'b1;
    frame_data  = mk(1, 1, 1, 64'h99, 16'h9, 6'h9);
    step(2);
    chk("f_wv", 96'(wvalid), 96'(1));
    #2 rst_n = 1'b0;
    #1 chk_rst("f_rst");
    frame_valid = 1'b0;
    do_reset(16'd0);
    f = mk(1, 1, 1, 64'hCAFE, 16'h00AA, 6'h11);
    exp_w.push_back(f);
    frame_valid = 1'b1;
    frame_data  = f;
    step(1);
    chk("f_wrs", 96'(wr_start), 96'(1));
    wait_acc("f_wr");
    frame_valid = 1'b0;
    wr_done = 1'b1;
    step(1);
    wr_done = 1'b0;
    chk("f_idle", 96'(busy), 96'(0));

    step(2);
    chk("wq_left", 96'(exp_w.size()), 96'(0));
    chk("rq_left", 96'(exp_r.size()), 96'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
